// File: rtl/div_seq.sv
// div_seq: radix-2 restoring sequential divider, unsigned and signed.
// Produces quotient, modulus, fractional word and divide-by-zero flag.
module div_seq #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         signed_mode,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         ready,
    output logic         valid,
    output logic [W-1:0] quotient,
    output logic [W-1:0] modulus,
    output logic [W-1:0] ex,
    output logic         divz
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    localparam int            CW   = $clog2(2 * W) + 1;
    localparam logic [CW-1:0] LAST = CW'(2 * W - 1);
    localparam logic [CW-1:0] MID  = CW'(W - 1);

    state_t         r_state;
    state_t         w_next;

    logic [2*W-1:0] r_nq;
    logic [W-1:0]   r_rem;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_r;
    logic [CW-1:0]  r_cnt;
    logic           r_neg;
    logic           r_sa;

    logic [W-1:0]   r_q;
    logic [W-1:0]   r_m;
    logic [W-1:0]   r_e;
    logic           r_z;

    logic           w_accept;
    logic           w_bz;
    logic           w_sa;
    logic           w_sb;
    logic [W-1:0]   w_abs_a;
    logic [W-1:0]   w_abs_b;
    logic [W:0]     w_shift;
    logic           w_ge;
    logic [W-1:0]   w_rem_nx;
    logic [W-1:0]   w_qhi;
    logic [W-1:0]   w_fq;
    logic [W-1:0]   w_fe;
    logic [W-1:0]   w_fm;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_bz     = (divisor == '0);
    assign w_sa     = signed_mode & dividend[W-1];
    assign w_sb     = signed_mode & divisor[W-1];
    // The most negative value negates onto itself, read back as 2^(W-1).
    assign w_abs_a  = w_sa ? -dividend : dividend;
    assign w_abs_b  = w_sb ? -divisor : divisor;

    // One shift-subtract-restore step; numerator bits leave the top of
    // r_nq while quotient bits enter at the bottom.
    assign w_shift  = {r_rem, r_nq[2*W-1]};
    assign w_ge     = (w_shift >= {1'b0, r_b});
    assign w_rem_nx = w_ge ? (w_shift[W-1:0] - r_b) : w_shift[W-1:0];

    // Sign fix-up; the low word of -Q equals the negation of the low word.
    assign w_qhi    = r_nq[2*W-1:W];
    assign w_fq     = r_neg ? -w_qhi : w_qhi;
    assign w_fe     = r_neg ? -r_nq[W-1:0] : r_nq[W-1:0];
    assign w_fm     = r_sa ? -r_r : r_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a zero divisor skips straight to DONE.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_bz ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == LAST) begin
                    w_next = S_FIX;
                end
            end
            S_FIX:  w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        ready = 1'b0;
        valid = 1'b0;
        unique case (r_state)
            S_IDLE:  ready = 1'b1;
            S_DONE:  valid = 1'b1;
            default: ;
        endcase
    end

    // Iterative datapath: load magnitudes on accept, step during CALC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nq  <= '0;
            r_rem <= '0;
            r_b   <= '0;
            r_r   <= '0;
            r_cnt <= '0;
            r_neg <= 1'b0;
            r_sa  <= 1'b0;
        end else if (w_accept) begin
            r_nq  <= {w_abs_a, {W{1'b0}}};
            r_rem <= '0;
            r_b   <= w_abs_b;
            r_cnt <= '0;
            r_neg <= w_sa ^ w_sb;
            r_sa  <= w_sa;
        end else if (r_state == S_CALC) begin
            r_nq  <= {r_nq[2*W-2:0], w_ge};
            r_rem <= w_rem_nx;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == MID) begin
                r_r <= w_rem_nx;
            end
        end
    end

    // Result registers: load in FIX or on the zero-divisor path, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
            r_m <= '0;
            r_e <= '0;
            r_z <= 1'b0;
        end else if (r_state == S_FIX) begin
            r_q <= w_fq;
            r_m <= w_fm;
            r_e <= w_fe;
            r_z <= 1'b0;
        end else if (w_accept && w_bz) begin
            r_q <= '0;
            r_m <= '0;
            r_e <= '0;
            r_z <= 1'b1;
        end
    end

    assign quotient = r_q;
    assign modulus  = r_m;
    assign ex       = r_e;
    assign divz     = r_z;
endmodule
